// File: rtl/ps_seq_pkg.sv
// Shared types and constants for the ps_sequencer fetch/decode/execute controller.
// FS code 5'h1F is reserved: ALU-class opcodes carrying it (e.g. IR=0x7E00) decode as illegal.
package ps_seq_pkg;

    localparam int CW_W  = 19;
    localparam int CW_DA = 16;
    localparam int CW_AA = 13;
    localparam int CW_BA = 10;
    localparam int CW_MB = 9;
    localparam int CW_FS = 4;
    localparam int CW_MD = 3;
    localparam int CW_RW = 2;
    localparam int CW_MW = 1;
    localparam int CW_PL = 0;

    localparam logic [6:0] OP_LD   = 7'b1000000;
    localparam logic [6:0] OP_ST   = 7'b1000001;
    localparam logic [6:0] OP_BRZ  = 7'b1100000;
    localparam logic [6:0] OP_BRN  = 7'b1100001;
    localparam logic [6:0] OP_JMP  = 7'b1100010;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    localparam logic [4:0] FS_RSVD = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

endpackage

// File: rtl/ps_seq_decoder.sv
// Combinational IR decode: instruction class flags plus the full control word
// (RW/MW as they apply on completion, PL left for the sequencer to drive).
module ps_seq_decoder
    import ps_seq_pkg::*;
(
    input  logic [15:0]     i_ir,
    output logic [CW_W-1:0] o_cw,
    output logic            o_is_alu,
    output logic            o_is_ld,
    output logic            o_is_st,
    output logic            o_is_brz,
    output logic            o_is_brn,
    output logic            o_is_jmp,
    output logic            o_is_halt,
    output logic            o_is_illegal
);

    logic [6:0] w_op;
    assign w_op = i_ir[15:9];

    always_comb begin
        o_cw         = '0;
        o_is_alu     = 1'b0;
        o_is_ld      = 1'b0;
        o_is_st      = 1'b0;
        o_is_brz     = 1'b0;
        o_is_brn     = 1'b0;
        o_is_jmp     = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;

        if (!w_op[6]) begin
            if (w_op[4:0] == FS_RSVD) begin
                o_is_illegal = 1'b1;
            end else begin
                o_is_alu           = 1'b1;
                o_cw[CW_MB]        = w_op[5];
                o_cw[CW_FS +: 5]   = w_op[4:0];
                o_cw[CW_RW]        = 1'b1;
            end
        end else begin
            case (w_op)
                OP_LD: begin
                    o_is_ld     = 1'b1;
                    o_cw[CW_MD] = 1'b1;
                    o_cw[CW_RW] = 1'b1;
                end
                OP_ST: begin
                    o_is_st     = 1'b1;
                    o_cw[CW_MW] = 1'b1;
                end
                OP_BRZ:  o_is_brz     = 1'b1;
                OP_BRN:  o_is_brn     = 1'b1;
                OP_JMP:  o_is_jmp     = 1'b1;
                OP_HALT: o_is_halt    = 1'b1;
                default: o_is_illegal = 1'b1;
            endcase
        end

        if (!(o_is_illegal || o_is_halt)) begin
            o_cw[CW_DA +: 3] = i_ir[8:6];
            o_cw[CW_AA +: 3] = i_ir[5:3];
            o_cw[CW_BA +: 3] = i_ir[2:0];
        end
    end

endmodule

// File: rtl/ps_sequencer.sv
// Multi-cycle fetch/decode/execute controller owning PC and IR.
// PS_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt in DECODE instead of executing as a NOP.
module ps_sequencer
    import ps_seq_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    input  logic            dmem_ack,
    input  logic            flag_z,
    input  logic            flag_n,
    output logic [CW_W-1:0] cntrl_word,
    output logic [3:0]      bs_out,
    output logic [15:0]     lit_out,
    output logic [15:0]     inst_out,
    output logic [PC_W-1:0] pc_out,
    output logic            halted
);

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;

    logic [CW_W-1:0] w_dec_cw;
    logic            w_is_alu, w_is_ld, w_is_st, w_is_brz, w_is_brn, w_is_jmp;
    logic            w_is_halt, w_is_illegal;
    logic            w_take;
    logic            w_idle;
    logic [PC_W-1:0] w_off;

    ps_seq_decoder u_dec (
        .i_ir         (r_ir),
        .o_cw         (w_dec_cw),
        .o_is_alu     (w_is_alu),
        .o_is_ld      (w_is_ld),
        .o_is_st      (w_is_st),
        .o_is_brz     (w_is_brz),
        .o_is_brn     (w_is_brn),
        .o_is_jmp     (w_is_jmp),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    // Offset {DR,SB} is 6-bit signed, added to the already-incremented PC.
    assign w_off  = {{(PC_W-6){r_ir[8]}}, r_ir[8:6], r_ir[2:0]};
    assign w_take = w_is_jmp | (w_is_brz & flag_z) | (w_is_brn & flag_n);
    assign w_idle = (r_state == S_IDLE);

    assign pc_out    = w_idle ? '0 : r_pc;
    assign imem_addr = w_idle ? '0 : r_pc;
    assign inst_out  = w_idle ? '0 : r_ir;
    assign bs_out    = w_idle ? '0 : r_ir[3:0];
    assign lit_out   = w_idle ? '0 : {13'd0, r_ir[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH && imem_ack) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + PC_W'(1);
            end else if (r_state == S_EXEC && w_take) begin
                r_pc <= r_pc + w_off;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        halted      = 1'b0;
        cntrl_word  = '0;

        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
`ifdef PS_SEQ_ILLEGAL_TRAP_EN
                w_state_nxt = (w_is_halt || w_is_illegal) ? S_HALT : S_EXEC;
`else
                w_state_nxt = w_is_halt ? S_HALT : S_EXEC;
`endif
            end
            S_EXEC: begin
                w_state_nxt = run ? S_FETCH : S_IDLE;
                if (w_is_illegal) begin
                    cntrl_word = '0;
                end else if (w_is_ld || w_is_st) begin
                    // Register write / store strobe wait for the data ack in MEM.
                    cntrl_word        = w_dec_cw;
                    cntrl_word[CW_RW] = 1'b0;
                    cntrl_word[CW_MW] = 1'b0;
                    w_state_nxt       = S_MEM;
                end else if (w_is_alu) begin
                    cntrl_word = w_dec_cw;
                end else if (w_is_brz || w_is_brn || w_is_jmp) begin
                    cntrl_word        = w_dec_cw;
                    cntrl_word[CW_PL] = w_take;
                end
            end
            S_MEM: begin
                dmem_req          = 1'b1;
                cntrl_word        = w_dec_cw;
                cntrl_word[CW_RW] = w_dec_cw[CW_RW] & dmem_ack;
                cntrl_word[CW_MW] = w_dec_cw[CW_MW] & dmem_ack;
                if (dmem_ack) w_state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps_sequencer.sv
// Scoreboard bench for ps_sequencer: an ISA-level model predicts fetch addresses and
// control-word events; a monitor compares them against what the DUT presents.
module tb_ps_sequencer;

    localparam int          PC_W   = 16;
    localparam logic [15:0] RST_PC = 16'hFFFD;
    localparam int          NRAND  = 400;

    logic        clk = 1'b0;
    logic        rst_n, run, imem_req, imem_ack, dmem_req, dmem_ack, flag_z, flag_n, halted;
    logic [15:0] imem_addr, imem_rdata, lit_out, inst_out, pc_out;
    logic [18:0] cntrl_word;
    logic [3:0]  bs_out;

    ps_sequencer #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .flag_z(flag_z), .flag_n(flag_n),
        .cntrl_word(cntrl_word), .bs_out(bs_out), .lit_out(lit_out), .inst_out(inst_out),
        .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic [1:0]  flagtab [0:4095];   // {n, z} per dynamic instruction
    logic [15:0] exp_fetch [$];
    logic [18:0] exp_cw [$];
    int          fetch_cyc [$];
    int          dm_len [$];
    bit          dm_md [$];
    int checks = 0, errors = 0;
    int cyc = 0, nfetch = 0, stop_after = 0, halt_fetch = 0;
    int i_cnt = 0, i_tgt = 0, d_cnt = 0, d_tgt = 0, i_fix = 0, d_fix = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [18:0] mkcw(input logic [2:0] da, aa, ba, input logic mb,
                                         input logic [4:0] fs, input logic md, rw, mw, pl);
        return {da, aa, ba, mb, fs, md, rw, mw, pl};
    endfunction

    function automatic bit legal(input logic [6:0] op);
        if (!op[6]) return op[4:0] != 5'h1F;
        return op inside {7'h40, 7'h41, 7'h60, 7'h61, 7'h62, 7'h7F};
    endfunction

    // Instruction-set interpreter: walks the program and records what the DUT must show.
    task automatic model(input int nmax);
        logic [15:0] pc, ir, off;
        logic [6:0]  op;
        logic [2:0]  dr, sa, sb;
        pc = RST_PC;
        for (int k = 0; k < nmax; k++) begin
            ir = mem[pc];
            exp_fetch.push_back(pc);
            pc = pc + 16'd1;
            op = ir[15:9]; dr = ir[8:6]; sa = ir[5:3]; sb = ir[2:0];
            off = {{10{dr[2]}}, dr, sb};
            if (op == 7'h7F) break;
            if (!legal(op)) begin
`ifdef PS_SEQ_ILLEGAL_TRAP_EN
                break;
`else
                continue;
`endif
            end
            if (!op[6])           exp_cw.push_back(mkcw(dr, sa, sb, op[5], op[4:0], 1'b0, 1'b1, 1'b0, 1'b0));
            else if (op == 7'h40) exp_cw.push_back(mkcw(dr, sa, sb, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
            else if (op == 7'h41) exp_cw.push_back(mkcw(dr, sa, sb, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            else if (op == 7'h62 || (op == 7'h60 && flagtab[k][0]) || (op == 7'h61 && flagtab[k][1])) begin
                exp_cw.push_back(mkcw(dr, sa, sb, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                pc = pc + off;
            end
        end
    endtask

    // Memory/flag driver: acks after a fixed or random number of wait cycles.
    initial begin
        imem_ack = 0; dmem_ack = 0; imem_rdata = '0; flag_z = 0; flag_n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_ack = 0; dmem_ack = 0; i_cnt = 0; d_cnt = 0;
            end else begin
                if (imem_req && i_cnt >= i_tgt) begin
                    imem_ack = 1; imem_rdata = mem[imem_addr];
                    {flag_n, flag_z} = flagtab[nfetch % 4096];
                    nfetch++;
                    if (stop_after != 0 && nfetch >= stop_after) run = 0;
                    i_cnt = 0; i_tgt = (i_fix >= 0) ? i_fix : int'($urandom_range(0, 2));
                end else begin
                    imem_ack = 0;
                    if (imem_req) i_cnt++;
                end
                if (dmem_req && d_cnt >= d_tgt) begin
                    dmem_ack = 1;
                    d_cnt = 0; d_tgt = (d_fix >= 0) ? d_fix : int'($urandom_range(0, 2));
                end else begin
                    dmem_ack = 0;
                    if (dmem_req) d_cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a fetch or asserts RW/MW/PL.
    initial begin
        logic [15:0] pend_pc;
        bit          pend = 0, md_and = 1;
        int          len = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (!rst_n) continue;
            if (imem_req && imem_ack) begin
                fetch_cyc.push_back(cyc);
                if (exp_fetch.size() == 0) chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
                else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
                chk("fetch_cw", cntrl_word, 0);
                pend_pc = imem_addr + 16'd1; pend = 1;
            end else if (pend) begin
                chk("pc_inc", pc_out, pend_pc);
                chk("decode_cw", cntrl_word, 0);
                pend = 0;
            end
            if (cntrl_word[2:0] != 3'b000) begin
                if (exp_cw.size() == 0) chk("unexpected_cw", cntrl_word, 32'hFFFF_FFFF);
                else chk("cntrl_word", cntrl_word, exp_cw.pop_front());
            end
            if (dmem_req) begin
                len++; md_and &= cntrl_word[3];
                if (!dmem_ack) chk("mem_wait_strobes", cntrl_word[2:0], 0);
                else begin dm_len.push_back(len); dm_md.push_back(md_and); len = 0; md_and = 1; end
            end
            if (halted && imem_req) halt_fetch++;
        end
    end

    initial begin
        logic [15:0] r, ir;
        logic [6:0]  op;
        logic [6:0]  ill [4] = '{7'h42, 7'h7E, 7'h1F, 7'h70};
        rst_n = 0; run = 0;
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        for (int a = 0; a < 4096; a++) flagtab[a] = '0;

        // Reset asserted while a fetch is stalled.
        i_fix = 1000; i_tgt = 1000;
        repeat (2) @(negedge clk);
        rst_n = 1; run = 1;
        repeat (3) @(negedge clk); #2;
        chk("pre_reset_imem_req", imem_req, 1);
        rst_n = 0; #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_cntrl_word", cntrl_word, 0);
        chk("rst_halted", halted, 0);
        chk("rst_inst_out", inst_out, 0);
        run = 0;

        // Directed program, starting at RESET_PC and wrapping through 0xFFFF.
        mem[16'hFFFD] = 16'h0ACA;  // ALU FS=00101 DR3 SA1 SB2
        mem[16'hFFFE] = 16'h8050;  // LD DR1 SA2
        mem[16'hFFFF] = 16'h4293;  // ALU imm FS=00001
        mem[16'h0000] = 16'hC404;  // JMP +4 -> 5
        mem[16'h0005] = 16'hC1C6;  // BRZ -2
        mem[16'h0004] = 16'hC400;  // JMP +0 -> 5
        mem[16'h0006] = 16'h7E00;  // illegal
        mem[16'h0007] = 16'hC201;  // BRN +1 -> 9
        mem[16'h0009] = 16'h832E;  // ST
        mem[16'h000A] = 16'hFE00;  // HALT
        flagtab[4] = 2'b01;        // first BRZ taken, second (index 6) not
        flagtab[8] = 2'b10;        // BRN taken
        model(64);
        nfetch = 0; stop_after = 0;
        i_fix = 0; i_tgt = 0; d_fix = 2; d_tgt = 2;
        @(negedge clk); #2;
        fetch_cyc.delete(); dm_len.delete(); dm_md.delete();
        rst_n = 1; run = 1;
        for (int t = 0; t < 300 && !halted; t++) @(negedge clk);
        repeat (10) @(negedge clk); #2;
        chk("halted", halted, 1);
        chk("halt_imem_req", imem_req, 0);
        chk("halt_fetches", halt_fetch, 0);
`ifdef PS_SEQ_ILLEGAL_TRAP_EN
        chk("halt_inst", inst_out, 16'h7E00);
`else
        chk("halt_inst", inst_out, 16'hFE00);
`endif
        chk("dir_fetch_left", exp_fetch.size(), 0);
        chk("dir_cw_left", exp_cw.size(), 0);
        if (fetch_cyc.size() >= 5 && dm_len.size() >= 1) begin
            chk("alu_latency", fetch_cyc[1] - fetch_cyc[0], 3);
            chk("ld_latency", fetch_cyc[2] - fetch_cyc[1], 6);
            chk("jmp_latency", fetch_cyc[4] - fetch_cyc[3], 3);
            chk("ld_dmem_req_cycles", dm_len[0], 3);
            chk("ld_md_held", dm_md[0], 1);
        end else chk("dir_events_seen", fetch_cyc.size(), 5);

        // Randomized program with random memory wait states; run drops after NRAND fetches.
        rst_n = 0; run = 0; #1;
        exp_fetch.delete(); exp_cw.delete();
        for (int a = 0; a < 65536; a++) begin
            r = 16'($urandom());
`ifdef PS_SEQ_ILLEGAL_TRAP_EN
            case ($urandom_range(0, 6))
`else
            case ($urandom_range(0, 7))
`endif
                0: op = {2'b00, 5'($urandom_range(0, 30))};
                1: op = {2'b01, 5'($urandom_range(0, 30))};
                2: op = 7'h40;
                3: op = 7'h41;
                4: op = 7'h60;
                5: op = 7'h61;
                6: op = 7'h62;
                default: op = ill[$urandom_range(0, 3)];
            endcase
            ir = {op, r[8:0]};
            mem[a] = ir;
        end
        for (int a = 0; a < 4096; a++) flagtab[a] = 2'($urandom());
        model(NRAND);
        nfetch = 0; stop_after = NRAND; halt_fetch = 0;
        i_fix = -1; d_fix = -1; i_tgt = 1; d_tgt = 0;
        @(negedge clk); #2;
        rst_n = 1; run = 1;
        for (int t = 0; t < 20000 && nfetch < NRAND; t++) @(negedge clk);
        repeat (30) @(negedge clk); #2;
        chk("rand_fetches", nfetch, NRAND);
        chk("rand_fetch_left", exp_fetch.size(), 0);
        chk("rand_cw_left", exp_cw.size(), 0);
        chk("idle_imem_req", imem_req, 0);
        chk("idle_pc_out", pc_out, 0);
        chk("idle_halted", halted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
